// File: rtl/pipefft_pkg.sv
// Shared types and helpers for the pipelined FFT: complex sample layout, the
// {im, re} delay-memory word, and the halving butterfly arithmetic.
package pipefft_pkg;

    localparam int DW  = 34;
    localparam int DLY = 16;
    localparam int AW  = 4;

    // Packed with im first so the struct bits are already the {im, re} memory word.
    typedef struct packed {
        logic signed [DW-1:0] im;
        logic signed [DW-1:0] re;
    } cplx_t;

    typedef enum logic {
        PH_FILL = 1'b0,
        PH_BFLY = 1'b1
    } phase_t;

    function automatic logic [2*DW-1:0] pack(input cplx_t c);
        return {c.im, c.re};
    endfunction

    function automatic cplx_t unpack(input logic [2*DW-1:0] w);
        cplx_t c;
        c.im = w[2*DW-1:DW];
        c.re = w[DW-1:0];
        return c;
    endfunction

    // One guard bit, then drop the LSB: floor((a+b)/2) always fits back in DW bits.
    function automatic logic signed [DW-1:0] halfSum(input logic signed [DW-1:0] a,
                                                     input logic signed [DW-1:0] b);
        logic signed [DW:0] s;
        s = {a[DW-1], a} + {b[DW-1], b};
        return s[DW:1];
    endfunction

    function automatic logic signed [DW-1:0] halfDiff(input logic signed [DW-1:0] a,
                                                      input logic signed [DW-1:0] b);
        logic signed [DW:0] d;
        d = {a[DW-1], a} - {b[DW-1], b};
        return d[DW:1];
    endfunction

    function automatic cplx_t cHalfSum(input cplx_t a, input cplx_t b);
        cplx_t r;
        r.re = halfSum(a.re, b.re);
        r.im = halfSum(a.im, b.im);
        return r;
    endfunction

    function automatic cplx_t cHalfDiff(input cplx_t a, input cplx_t b);
        cplx_t r;
        r.re = halfDiff(a.re, b.re);
        r.im = halfDiff(a.im, b.im);
        return r;
    endfunction

endpackage

// File: rtl/pipefft_sdf_bfly_16.sv
// Radix-2 DIF single-delay-feedback butterfly stage; drives an external
// 16-deep delay memory with 2-cycle registered read latency.
module pipefft_sdf_bfly_16
    import pipefft_pkg::*;
#(
    parameter int DLY = pipefft_pkg::DLY,
    parameter int AW  = pipefft_pkg::AW,
    parameter int DW  = pipefft_pkg::DW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inValid,
    input  logic [DW-1:0]     inRe,
    input  logic [DW-1:0]     inIm,
    output logic              outValid,
    output logic [DW-1:0]     outRe,
    output logic [DW-1:0]     outIm,
    output logic              outSum,
    output logic [AW-1:0]     ramRAddr,
    output logic [AW-1:0]     ramWAddr,
    output logic              ramWEn,
    output logic [2*DW-1:0]   ramWD,
    input  logic [2*DW-1:0]   ramRD
);

    typedef struct packed {
        logic          valid;
        phase_t        phase;
        logic [AW-1:0] slot;
        cplx_t         x;
    } pipe_t;

    logic [AW:0] cnt;
    pipe_t       s1;
    pipe_t       s2;
    logic        primed;

    cplx_t a;
    cplx_t b;
    cplx_t sumC;
    cplx_t diffC;
    cplx_t wrData;

    // The memory registers this address itself, so it is driven straight from the counter.
    assign ramRAddr = cnt[AW-1:0];

    // NOTE: state is updated with non-blocking assignments so every register samples
    // pre-edge values; blocking here would make s2 see this cycle's s1 and collapse the pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            s1  <= '0;
            s2  <= '0;
        end else begin
            if (inValid) begin
                cnt <= cnt + (AW+1)'(1);
            end
            s1.valid <= inValid;
            s1.phase <= phase_t'(cnt[AW]);
            s1.slot  <= cnt[AW-1:0];
            s1.x     <= '{im: inIm, re: inRe};
            s2       <= s1;
        end
    end

    // NOTE: every signal gets a value on every path through this block, so no latch is inferred.
    always_comb begin
        a      = unpack(ramRD);
        b      = s2.x;
        sumC   = cHalfSum(a, b);
        diffC  = cHalfDiff(a, b);
        wrData = (s2.phase == PH_BFLY) ? diffC : b;
    end

    // Read-before-write on the same slot is guaranteed by the DLY-sample spacing.
    assign ramWEn   = s2.valid;
    assign ramWAddr = s2.slot;
    assign ramWD    = pack(wrData);

    always_ff @(posedge clk) begin
        if (rst) begin
            primed   <= 1'b0;
            outValid <= 1'b0;
            outRe    <= '0;
            outIm    <= '0;
            outSum   <= 1'b0;
        end else begin
            if (s2.valid && s2.phase == PH_BFLY) begin
                primed <= 1'b1;
            end
            // Fill-phase reads before the first butterfly return stale memory, so hide them.
            outValid <= s2.valid && (s2.phase == PH_BFLY || primed);
            if (s2.valid) begin
                if (s2.phase == PH_BFLY) begin
                    outRe  <= sumC.re;
                    outIm  <= sumC.im;
                    outSum <= 1'b1;
                end else begin
                    outRe  <= a.re;
                    outIm  <= a.im;
                    outSum <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipefft_sdf_bfly_16.sv
// Scoreboard bench: a per-sample SDF reference model predicts outputs and memory
// writes; a negedge monitor compares them against the DUT and its latency.
module tb_pipefft_sdf_bfly_16;
    import pipefft_pkg::*;

    localparam int W = pipefft_pkg::DW;
    localparam int D = pipefft_pkg::DLY;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           inValid = 1'b0;
    logic [W-1:0]   inRe = '0;
    logic [W-1:0]   inIm = '0;
    logic           outValid;
    logic [W-1:0]   outRe;
    logic [W-1:0]   outIm;
    logic           outSum;
    logic [3:0]     ramRAddr;
    logic [3:0]     ramWAddr;
    logic           ramWEn;
    logic [2*W-1:0] ramWD;
    logic [2*W-1:0] ramRD = '0;

    always #5 clk = ~clk;

    pipefft_sdf_bfly_16 dut (
        .clk(clk), .rst(rst), .inValid(inValid), .inRe(inRe), .inIm(inIm),
        .outValid(outValid), .outRe(outRe), .outIm(outIm), .outSum(outSum),
        .ramRAddr(ramRAddr), .ramWAddr(ramWAddr), .ramWEn(ramWEn),
        .ramWD(ramWD), .ramRD(ramRD)
    );

    // Delay memory macro: registered address, registered data.
    logic [2*W-1:0] mem [D] = '{default: '0};
    logic [3:0]     rAddrQ = '0;
    always @(posedge clk) begin
        rAddrQ <= ramRAddr;
        ramRD  <= mem[rAddrQ];
        if (ramWEn) mem[ramWAddr] <= ramWD;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct { int k; longint re; longint im; bit sum; } outExp_t;
    typedef struct { int k; int slot; longint re; longint im; } wrExp_t;
    typedef struct { int k; int slot; longint re; longint im; } undo_t;

    outExp_t expOut[$];
    wrExp_t  expWr[$];
    undo_t   undoQ[$];

    longint mRe [D];
    longint mIm [D];
    int     mCnt = 0;
    bit     mPrimed = 0;
    int     edgeNo = 0;
    bit     started = 0;

    function automatic longint sext(input logic [W-1:0] v);
        return longint'($signed(v));
    endfunction

    // Reference model: each accepted sample is applied to the delay line at once.
    initial begin
        for (int i = 0; i < D; i++) begin mRe[i] = 0; mIm[i] = 0; end
        forever begin
            @(posedge clk);
            edgeNo++;
            if (rst) begin
                // Samples still in the pipe at the reset edge are lost.
                while (undoQ.size() > 0 && undoQ[$].k >= edgeNo - 1) begin
                    mRe[undoQ[$].slot] = undoQ[$].re;
                    mIm[undoQ[$].slot] = undoQ[$].im;
                    void'(undoQ.pop_back());
                end
                while (expOut.size() > 0 && expOut[$].k >= edgeNo - 2) void'(expOut.pop_back());
                while (expWr.size() > 0 && expWr[$].k >= edgeNo - 1) void'(expWr.pop_back());
                mCnt    = 0;
                mPrimed = 0;
            end else if (inValid) begin
                int     slot;
                longint xr, xi, ar, ai, nr, ni;
                slot = mCnt % D;
                xr = sext(inRe); xi = sext(inIm);
                ar = mRe[slot];  ai = mIm[slot];
                if (mCnt < D) begin
                    if (mPrimed) expOut.push_back('{edgeNo, ar, ai, 1'b0});
                    nr = xr; ni = xi;
                end else begin
                    mPrimed = 1;
                    expOut.push_back('{edgeNo, (ar + xr) >>> 1, (ai + xi) >>> 1, 1'b1});
                    nr = (ar - xr) >>> 1; ni = (ai - xi) >>> 1;
                end
                undoQ.push_back('{edgeNo, slot, ar, ai});
                if (undoQ.size() > 4) void'(undoQ.pop_front());
                expWr.push_back('{edgeNo, slot, nr, ni});
                mRe[slot] = nr; mIm[slot] = ni;
                mCnt = (mCnt + 1) % (2 * D);
            end
        end
    end

    // Monitor: compare whatever the DUT presents, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (started && outValid) begin
                if (expOut.size() == 0) begin
                    check("outUnexpected", 1, 0);
                end else begin
                    outExp_t e;
                    e = expOut.pop_front();
                    check("outRe", sext(outRe), e.re);
                    check("outIm", sext(outIm), e.im);
                    check("outSum", longint'(outSum), longint'(e.sum));
                    check("outLatency", edgeNo, e.k + 2);
                end
            end
            if (started && ramWEn) begin
                if (expWr.size() == 0) begin
                    check("wrUnexpected", 1, 0);
                end else begin
                    wrExp_t w;
                    w = expWr.pop_front();
                    check("ramWAddr", longint'(ramWAddr), longint'(w.slot));
                    check("ramWDre", sext(ramWD[W-1:0]), w.re);
                    check("ramWDim", sext(ramWD[2*W-1:W]), w.im);
                    check("wrLatency", edgeNo, w.k + 1);
                end
            end
        end
    end

    task automatic drive(input bit v, input longint re, input longint im);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        inValid = v;
        inRe    = re[W-1:0];
        inIm    = im[W-1:0];
    endtask

    task automatic pulseReset(input bit v, input longint re);
        @(posedge clk);
        #1;
        rst     = 1'b1;
        inValid = v;
        inRe    = re[W-1:0];
        inIm    = '0;
    endtask

    localparam longint FS_POS = (64'sd1 <<< 33) - 1;
    localparam longint FS_NEG = -(64'sd1 <<< 33);

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rstOutValid", longint'(outValid), 0);
        check("rstOutRe", sext(outRe), 0);
        check("rstOutIm", sext(outIm), 0);
        check("rstOutSum", longint'(outSum), 0);
        check("rstRamWEn", longint'(ramWEn), 0);
        check("rstRamRAddr", longint'(ramRAddr), 0);
        check("rstRamWAddr", longint'(ramWAddr), 0);
        check("rstRamWD", sext(ramWD[W-1:0]) | sext(ramWD[2*W-1:W]), 0);
        started = 1;

        // Ramp over two frames.
        for (int n = 0; n < 64; n++) drive(1'b1, n, 0);

        // Imaginary part and floor rounding of negative halves.
        for (int n = 0; n < 2 * D; n++) drive(1'b1, 3 * n, (n < D) ? -3 : 0);
        for (int n = 0; n < D; n++) drive(1'b1, 0, 0);

        // Full scale on both extremes.
        for (int n = 0; n < 2 * D; n++) drive(1'b1, FS_POS, FS_NEG);
        for (int n = 0; n < D; n++) drive(1'b1, -5, 7);

        // Random values with 50% input duty.
        for (int n = 0; n < 400; n++) begin
            logic [W-1:0] r, i;
            r = W'({$urandom, $urandom});
            i = W'({$urandom, $urandom});
            drive(1'(($urandom % 2)), sext(r), sext(i));
        end
        drive(1'b0, 0, 0);

        // Reset mid-frame with samples in flight, then a fresh ramp.
        pulseReset(1'b0, 0);
        for (int n = 0; n < 20; n++) drive(1'b1, n, 0);
        pulseReset(1'b1, 20);
        for (int n = 0; n < 48; n++) drive(1'b1, 100 + n, -n);
        for (int n = 0; n < 10; n++) drive(1'b0, 0, 0);

        @(negedge clk);
        check("outQueueDrained", expOut.size(), 0);
        check("wrQueueDrained", expWr.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
